// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller.
//   state_t     : controller state encoding (IDLE=0, DRIVE=1, CHECK=2, FIN=3)
//   SETTLE_W    : width of the settle counter
//   gate_kind_t : selector for the built-in two-input truth tables
//   truth_of()  : returns the TRUTH constant for a two-input gate kind
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    GATE_NAND2 = 2'd0,
    GATE_AND2  = 2'd1,
    GATE_OR2   = 2'd2,
    GATE_XOR2  = 2'd3
  } gate_kind_t;

  // Bit i of the result is the gate output for input vector i.
  function automatic logic [3:0] truth_of(gate_kind_t kind);
    case (kind)
      GATE_NAND2: return 4'b0111;
      GATE_AND2:  return 4'b1000;
      GATE_OR2:   return 4'b1110;
      default:    return 4'b0110;
    endcase
  endfunction

endpackage

// File: rtl/nand2.sv
// Two-input NAND gate used as the gate under test.
//   a, b : gate inputs
//   y    : ~(a & b)
module nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/settle_timer.sv
// Settle-time counter for the sweep controller.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : synchronously clears the count (wins over en)
//   en         : increments the count
//   expire     : count has reached SETTLE-1
module settle_timer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [SETTLE_W-1:0] cnt;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sequenced, self-checking sweep of a small combinational gate.
// Drives every input vector in ascending order, waits SETTLE cycles per
// vector, compares dut_out against TRUTH and reports the result.
//   clk, rst_n  : clock and asynchronous active-low reset
//   start       : begin a sweep (accepted in IDLE only)
//   abort       : cancel a sweep in DRIVE or CHECK
//   dut_out     : output of the gate under test
//   dut_in      : registered vector applied to the gate
//   busy        : high in DRIVE and CHECK
//   done        : one-cycle pulse when a sweep completes
//   pass        : last completed sweep had zero mismatches
//   err_cnt     : mismatch count (0..2**N_IN)
//   fail_valid  : at least one mismatch seen
//   first_fail  : lowest failing vector, valid with fail_valid
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned          N_IN   = 2,
  parameter int unsigned          SETTLE = 1,
  parameter logic [2**N_IN-1:0]   TRUTH  = truth_of(GATE_NAND2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(2**N_IN - 1);

  state_t state, state_nxt;
  logic   expire;
  logic   last_vec;
  logic   mismatch;

  assign last_vec = (dut_in == LAST_VEC);
  assign mismatch = (dut_out != TRUTH[dut_in]);

  // The counter sits at 0 whenever we are outside DRIVE, so every entry
  // into DRIVE starts a fresh settle window.
  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state != DRIVE),
    .en     (state == DRIVE),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely
  // combinational; a path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (abort) state_nxt = IDLE;
               else if (expire) state_nxt = CHECK;
      CHECK:   if (abort) state_nxt = IDLE;
               else if (last_vec) state_nxt = FIN;
               else state_nxt = DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE) || (state == CHECK);
  end

  // Result registers. done/pass are set on the edge that enters FIN so the
  // pulse coincides with busy falling; pass folds in the final compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dut_in     <= '0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end
        DRIVE: begin
          if (abort) dut_in <= '0;
        end
        CHECK: begin
          if (abort) begin
            dut_in <= '0;
          end else begin
            if (mismatch) begin
              err_cnt <= err_cnt + 1'b1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                first_fail <= dut_in;
              end
            end
            if (last_vec) begin
              done <= 1'b1;
              pass <= (err_cnt == '0) && !mismatch;
            end else begin
              dut_in <= dut_in + 1'b1;
            end
          end
        end
        FIN: begin
          dut_in <= '0;
        end
        default: dut_in <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: a NAND2 configuration with a
// selectable gate (good / stuck-at-1 / AND2) and a NAND3 configuration.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;
  logic [1:0] gsel;

  // Configuration A: defaults (N_IN=2, SETTLE=1, NAND2 truth)
  logic [1:0] dut_in_a, ff_a;
  logic [2:0] err_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic       nand_y, out_a;

  nand2 u_nand2 (.a(dut_in_a[0]), .b(dut_in_a[1]), .y(nand_y));

  always_comb begin
    out_a = nand_y;
    if (gsel == 2'd1) out_a = 1'b1;
    else if (gsel == 2'd2) out_a = ~nand_y;
  end

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .TRUTH(truth_of(GATE_NAND2))) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(out_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .fail_valid(fv_a), .first_fail(ff_a)
  );

  // Configuration B: NAND3, SETTLE=3
  logic [2:0] dut_in_b, ff_b;
  logic [3:0] err_b;
  logic       busy_b, done_b, pass_b, fv_b, out_b;

  assign out_b = ~&dut_in_b;

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(3), .TRUTH(8'h7F)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(out_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .fail_valid(fv_b), .first_fail(ff_b)
  );

  typedef struct {
    int pass;
    int err;
    int fv;
    int ff;
    int start_cyc;
    int lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic p,
                              input logic [31:0] err, input logic fv,
                              input logic [31:0] ff, input logic busy);
    check({tag, ".latency"}, cyc - e.start_cyc, e.lat);
    check({tag, ".pass"}, p, e.pass);
    check({tag, ".err_cnt"}, err, e.err);
    check({tag, ".fail_valid"}, fv, e.fv);
    check({tag, ".first_fail"}, ff, e.ff);
    check({tag, ".busy_at_done"}, busy, 0);
  endtask

  // Monitors: pop an expected result whenever a DUT presents done.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a.unexpected_done", done_a, 0);
      end else begin
        e = q_a.pop_front();
        check_result("a", e, pass_a, err_a, fv_a, ff_a, busy_a);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b.unexpected_done", done_b, 0);
      end else begin
        e = q_b.pop_front();
        check_result("b", e, pass_b, err_b, fv_b, ff_b, busy_b);
      end
    end
  end

  // Pulse start for one cycle; c is the cycle count of the sampling edge.
  task automatic pulse_start_a(output int c);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    c = cyc;
  endtask

  task automatic pulse_start_b(output int c);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    c = cyc;
  endtask

  task automatic push_a(input int p, input int err, input int fv, input int ff, input int c);
    exp_t e;
    e = '{pass: p, err: err, fv: fv, ff: ff, start_cyc: c, lat: 8};
    q_a.push_back(e);
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a.done_seen", done_a, 1);
    @(negedge clk);
  endtask

  task automatic wait_done_b(input int budget);
    int n = 0;
    while (done_b !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("b.done_seen", done_b, 1);
    @(negedge clk);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, ".dut_in"}, dut_in_a, 0);
    check({tag, ".busy"}, busy_a, 0);
    check({tag, ".done"}, done_a, 0);
    check({tag, ".pass"}, pass_a, 0);
    check({tag, ".err_cnt"}, err_a, 0);
    check({tag, ".fail_valid"}, fv_a, 0);
    check({tag, ".first_fail"}, ff_a, 0);
  endtask

  initial begin
    int c;
    int n;
    exp_t eb;
    rst_n   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    gsel    = 2'd0;

    // Reset state
    #12;
    check_idle_a("reset_a");
    check("reset_b.busy", busy_b, 0);
    check("reset_b.dut_in", dut_in_b, 0);
    @(negedge clk) rst_n = 1'b1;

    // Good NAND2: dut_in steps 0,1,2,3 with two cycles each
    pulse_start_a(c);
    push_a(1, 0, 0, 0, c);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("good.dut_in[%0d]", i), dut_in_a, i / 2);
      check($sformatf("good.busy[%0d]", i), busy_a, 1);
      @(negedge clk);
    end
    wait_done_a(20);
    check("good.dut_in_after", dut_in_a, 0);
    check("good.pass_hold", pass_a, 1);

    // Output stuck-at-1: only vector 3 (expected 0) mismatches
    gsel = 2'd1;
    pulse_start_a(c);
    push_a(0, 1, 1, 3, c);
    wait_done_a(20);

    // AND2 against NAND2 truth: every vector mismatches
    gsel = 2'd2;
    pulse_start_a(c);
    push_a(0, 4, 1, 0, c);
    wait_done_a(20);
    check("and2.err_hold", err_a, 4);

    // NAND3, SETTLE=3: 8 vectors x 4 cycles
    pulse_start_b(c);
    eb = '{pass: 1, err: 0, fv: 0, ff: 0, start_cyc: c, lat: 32};
    q_b.push_back(eb);
    wait_done_b(100);

    // Abort in cycle 3 of a sweep
    gsel = 2'd0;
    pulse_start_a(c);             // now in cycle 1
    @(negedge clk);               // cycle 2
    @(negedge clk) abort_a = 1'b1; // cycle 3
    @(negedge clk) abort_a = 1'b0;
    check("abort.busy", busy_a, 0);
    check("abort.dut_in", dut_in_a, 0);
    check("abort.done", done_a, 0);
    check("abort.pass", pass_a, 0);
    repeat (12) @(negedge clk);
    check("abort.still_idle", busy_a, 0);

    // start pulsed during a DRIVE is ignored: length unchanged
    pulse_start_a(c);
    push_a(1, 0, 0, 0, c);
    @(negedge clk);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_done_a(20);
    repeat (10) @(negedge clk);

    // Reset mid-sweep at vector 2 with errors accumulating
    gsel = 2'd2;
    pulse_start_a(c);
    n = 0;
    while (dut_in_a != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst.reached_vec2", dut_in_a, 2);
    check("rst.err_before", err_a, 2);
    #1 rst_n = 1'b0;
    #1;
    check_idle_a("rst_async");
    @(negedge clk) rst_n = 1'b1;
    gsel = 2'd0;
    pulse_start_a(c);
    push_a(1, 0, 0, 0, c);
    wait_done_a(20);

    repeat (3) @(negedge clk);
    check("a.queue_empty", q_a.size(), 0);
    check("b.queue_empty", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sweep controller for a small combinational gate under test (e.g. `nand2`). On `start` it drives every input vector of an `N_IN`-input gate in ascending order and waits a programmable settle time per vector. It then compares the gate output against a truth-table parameter and reports pass/fail, the mismatch count and the first failing vector. It sits between a bench or on-chip BIST wrapper and the gate instance, replacing free-running `always #n` stimulus with a sequenced, checked sweep.

## Interface
- `N_IN`, 2: gate input count, 1..4.
- `SETTLE`, 1: DRIVE cycles per vector before compare, 1..15.
- `TRUTH`, 4'b0111: expected output; bit `i` is the output for input vector `i`. Width is `2**N_IN`. The default is the NAND2 truth table.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a sweep. Sampled only in IDLE.
- `abort`  in  1  cancels a sweep in progress.
- `dut_out`  in  1  output of the gate under test.
- `dut_in`  out  N_IN  registered vector applied to the gate.
- `busy`  out  1  high in DRIVE and CHECK.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  last completed sweep had zero mismatches.
- `err_cnt`  out  N_IN+1  mismatch count, range 0..2**N_IN.
- `fail_valid`  out  1  at least one mismatch seen in the current or last sweep.
- `first_fail`  out  N_IN  lowest failing vector; valid when `fail_valid` is high.

## Operation
- States: IDLE, DRIVE, CHECK, FIN.
- IDLE:
  - `start` high → DRIVE.
  - In the same edge: `dut_in`, `err_cnt`, `fail_valid`, `first_fail` and `pass` clear to 0, and the settle counter loads 0.
- DRIVE:
  - `dut_in` is held. The settle counter increments each cycle.
  - At count `SETTLE-1` → CHECK.
- CHECK:
  - Compare `dut_out` against `TRUTH[dut_in]`.
  - On mismatch: `err_cnt` +1. If `fail_valid` is 0, set it and capture `first_fail` = `dut_in`.
  - If `dut_in` = `2**N_IN-1` → FIN. Otherwise `dut_in` +1, counter reloads 0, → DRIVE.
- FIN: `done` = 1 and `pass` ← (`err_cnt` == 0) for exactly one cycle, then → IDLE. `dut_in` returns to 0.
- `abort`:
  - In DRIVE or CHECK, `abort` wins over every other transition: next state is IDLE, `dut_in` goes to 0, no `done`, and `pass` stays 0.
  - Partial `err_cnt`/`first_fail` are retained.
  - `abort` is ignored in IDLE and FIN.
- `start` while not in IDLE is ignored. `start` and `abort` together in IDLE: `start` is accepted.
- Results hold after FIN until the next accepted `start`.
- `err_cnt` cannot overflow: its width holds `2**N_IN`.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE
  - all outputs 0, i.e. `dut_in`, `busy`, `done`, `pass`, `err_cnt`, `fail_valid`, `first_fail`
- Reset mid-sweep: identical to power-on; no `done`.
- Each vector occupies `SETTLE+1` cycles: SETTLE in DRIVE plus 1 in CHECK.
- `done` goes high `2**N_IN*(SETTLE+1)` cycles after the rising edge that samples `start`. Default: 8 cycles.
- `dut_out` is sampled combinationally in CHECK. The gate has at least `SETTLE` full cycles of stable input before the compare.
- `busy` falls on the same edge `done` rises.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `gate_sweep_pkg`: state encoding (IDLE=0, DRIVE=1, CHECK=2, FIN=3), `SETTLE_W`=4, and a function returning the NAND2/AND2/OR2/XOR2 truth constants for `TRUTH`.
- Sub-module `settle_timer`: load/enable counter of width `SETTLE_W` with an `expire` output at `SETTLE-1`.
- Controller FSM and result registers stay in `gate_sweep_ctrl`.
- Bench instantiates `gate_sweep_ctrl` plus the existing `nand2`.

## Test plan
- **Good NAND2, defaults.**
  - Stimulus: `start` pulse.
  - Required: `dut_in` steps 0,1,2,3 with 2 cycles each; `done` 8 cycles after the `start` edge; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- **Output stuck-at-1 gate.**
  - Stimulus: defaults, gate output tied high.
  - Required: `err_cnt`=1, `first_fail`=3, `fail_valid`=1, `pass`=0.
- **AND2 gate against the NAND2 `TRUTH`.**
  - Required: `err_cnt`=4, `first_fail`=0, `pass`=0.
- **`SETTLE`=3, `N_IN`=3, `TRUTH`=8'h7F (NAND3), good gate.**
  - Required: `done` 32 cycles after `start`; `pass`=1.
- **Abort and ignored start.**
  - Stimulus: `abort` in cycle 3 of a sweep.
  - Required: IDLE next cycle, `dut_in`=0, no `done`, `pass`=0.
  - A `start` pulsed during a later DRIVE is ignored: the sweep length is unchanged.
- **Reset mid-sweep.**
  - Stimulus: `rst_n` low at vector 2.
  - Required: all outputs 0 immediately with no clock.
  - After release, a new `start` runs a full sweep with fresh results.
